// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the datapath and the data memory responder.
// The datapath is the master; the memory responder is the slave.
interface data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, stall, done, err
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, stall, done, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed multi-cycle access latency.
// The datapath is held with stall until each load/store completes.
//
// state | meaning
// IDLE  | waiting; stall mirrors the incoming request, request latched on sight
// BUSY  | counting down LATENCY cycles; access happens on the cnt == 0 edge
// DONE  | one-cycle completion pulse; request still present is not restarted
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    op_read;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             wdata_q;
    logic                    illegal;
    logic [31:0]             read_data_q;
    logic [31:0]             mem [2**ADDR_WIDTH];

    logic req, req_illegal, latch, do_access;
    logic stall_c, done_c, err_c;
    logic unused_addr_hi;

    assign req            = bus.mem_read | bus.mem_write;
    assign req_illegal    = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);
    // Upper byte-address bits alias modulo the memory depth.
    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        do_access = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                stall_c = req;
                if (req) begin
                    latch     = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                err_c     = illegal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_read     <= 1'b0;
            idx         <= '0;
            wdata_q     <= 32'd0;
            illegal     <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                op_read <= bus.mem_read & ~bus.mem_write;
                idx     <= bus.addr[ADDR_WIDTH+1:2];
                wdata_q <= bus.write_data;
                illegal <= req_illegal;
            end
            if (do_access && op_read && !illegal) begin
                read_data_q <= mem[idx];
            end
        end
    end

    // Array has no reset; reset forces IDLE, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (do_access && !op_read && !illegal) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.stall     = stall_c;
    assign bus.done      = done_c;
    assign bus.err       = err_c;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n_s = 1'b0;
    logic rst_n_f = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bs ();
    data_mem_responder_if bf ();

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut_s (.clk(clk), .rst_n(rst_n_s), .bus(bs.slave));
    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_f (.clk(clk), .rst_n(rst_n_f), .bus(bf.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc_cnt = 0;
    int          last_done = 0;
    bit          sel_fast = 1'b0;
    logic [31:0] mm_s [256];
    logic [31:0] mm_f [256];
    logic [31:0] mrd_s = 32'd0;
    logic [31:0] mrd_f = 32'd0;

    logic        s_stall, s_done, s_err;
    logic [31:0] s_rdata;
    assign s_stall = sel_fast ? bf.stall     : bs.stall;
    assign s_done  = sel_fast ? bf.done      : bs.done;
    assign s_err   = sel_fast ? bf.err       : bs.err;
    assign s_rdata = sel_fast ? bf.read_data : bs.read_data;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (sel_fast) begin
            bf.mem_read = rd; bf.mem_write = wr; bf.addr = a; bf.write_data = wd;
        end else begin
            bs.mem_read = rd; bs.mem_write = wr; bs.addr = a; bs.write_data = wd;
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Issues one request at the next falling edge, holds it while stalled, checks the DONE cycle.
    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
        int   lat;
        int   idx;
        bit   ill;
        bit   got;
        exp_t e;
        lat = sel_fast ? 1 : 2;
        ill = (rd && wr) || (a[1:0] != 2'b00);
        idx = int'(a[9:2]);
        @(negedge clk);
        drive(rd, wr, a, wd);
        if (sel_fast) begin
            if (!ill && wr) mm_f[idx] = wd;
            if (!ill && rd && !wr) mrd_f = mm_f[idx];
            e.rdata = mrd_f;
        end else begin
            if (!ill && wr) mm_s[idx] = wd;
            if (!ill && rd && !wr) mrd_s = mm_s[idx];
            e.rdata = mrd_s;
        end
        e.err = ill;
        exp_q.push_back(e);
        #1;
        total++;
        if (s_stall !== 1'b1 || s_done !== 1'b0) begin
            bad++;
            $display("FAIL %s cycle0: stall=%b done=%b, required stall=1 done=0", name, s_stall, s_done);
        end
        got = 1'b0;
        for (int c = 1; c <= lat + 4 && !got; c++) begin
            @(negedge clk);
            if (s_done === 1'b1) begin
                got = 1'b1;
                e = exp_q.pop_front();
                last_done = cyc_cnt;
                total++;
                if (c != lat + 1) begin
                    bad++;
                    $display("FAIL %s latency: done in cycle %0d, required cycle %0d", name, c, lat + 1);
                end
                total++;
                if (s_stall !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_stall: stall=%b, required 0", name, s_stall);
                end
                total++;
                if (s_err !== e.err) begin
                    bad++;
                    $display("FAIL %s err: got %b, required %b", name, s_err, e.err);
                end
                total++;
                if (s_rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL %s read_data: got %h, required %h", name, s_rdata, e.rdata);
                end
            end else begin
                total++;
                if (s_stall !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_stall cycle %0d: stall=%b, required 1", name, c, s_stall);
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s timeout: done never seen, required within %0d cycles", name, lat + 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        sel_fast = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        sel_fast = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        rst_n_s = 1'b0;
        rst_n_f = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_s = 1'b1;
        rst_n_f = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bs.read_data !== 32'd0 || bs.stall !== 1'b0 || bs.done !== 1'b0 || bs.err !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle_s: rd=%h stall=%b done=%b err=%b, required 0/0/0/0",
                         bs.read_data, bs.stall, bs.done, bs.err);
            end
            total++;
            if (bf.read_data !== 32'd0 || bf.stall !== 1'b0 || bf.done !== 1'b0 || bf.err !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle_f: rd=%h stall=%b done=%b err=%b, required 0/0/0/0",
                         bf.read_data, bf.stall, bf.done, bf.err);
            end
        end
    endtask

    task automatic test_write_read();
        sel_fast = 1'b0;
        access("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        release_bus();
        access("rd_10", 1'b1, 1'b0, 32'h10, 32'h0);
        release_bus();
    endtask

    task automatic test_illegal();
        sel_fast = 1'b0;
        access("rd_misaligned", 1'b1, 1'b0, 32'h13, 32'h0);
        release_bus();
        access("wr_20", 1'b0, 1'b1, 32'h20, 32'hCAFE0020);
        release_bus();
        access("rd_wr_conflict", 1'b1, 1'b1, 32'h20, 32'h0BAD0BAD);
        release_bus();
        access("rd_20_after", 1'b1, 1'b0, 32'h20, 32'h0);
        release_bus();
    endtask

    task automatic test_alias();
        sel_fast = 1'b0;
        access("wr_alias_404", 1'b0, 1'b1, 32'h0000_0404, 32'h1234);
        release_bus();
        access("rd_alias_4", 1'b1, 1'b0, 32'h4, 32'h0);
        release_bus();
    endtask

    task automatic test_reset_mid_write();
        sel_fast = 1'b0;
        access("wr_8_old", 1'b0, 1'b1, 32'h8, 32'h11);
        release_bus();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h8, 32'hAAAA5555);
        @(negedge clk);
        rst_n_s = 1'b0;
        #1;
        total++;
        if (bs.done !== 1'b0 || bs.read_data !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_out: done=%b rd=%h, required 0/00000000", bs.done, bs.read_data);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (bs.stall !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_idle: stall=%b, required 0", bs.stall);
        end
        @(negedge clk);
        rst_n_s = 1'b1;
        mrd_s = 32'd0;
        access("rd_8_after_reset", 1'b1, 1'b0, 32'h8, 32'h0);
        release_bus();
    endtask

    task automatic test_back_to_back();
        int dc [6];
        logic [31:0] vals [3];
        vals[0] = 32'h0101_0101;
        vals[1] = 32'h2020_2020;
        vals[2] = 32'h3C3C_3C3C;
        sel_fast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            access("b2b_wr", 1'b0, 1'b1, 32'(i * 4), vals[i]);
            dc[i] = last_done;
        end
        for (int i = 0; i < 3; i++) begin
            access("b2b_rd", 1'b1, 1'b0, 32'(i * 4), 32'h0);
            dc[3 + i] = last_done;
        end
        release_bus();
        for (int i = 1; i < 6; i++) begin
            total++;
            if (dc[i] - dc[i - 1] != 3) begin
                bad++;
                $display("FAIL b2b_spacing %0d: got %0d cycles, required 3", i, dc[i] - dc[i - 1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_alias();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
